// File: rtl/isqrt_pkg.sv
// -----------------------------------------------------------------------------
// isqrt_pkg
// Shared types and default sizes for the sequential integer square root.
//   state_e      : controller states (IDLE, CALC, DONE)
//   *_DEF        : default radicand / root / counter / remainder / trial widths
//   cnt_w()      : iteration counter width for a given root width
// -----------------------------------------------------------------------------
package isqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter counts OUT_W-1 down to 0; keep at least one bit for tiny roots.
  function automatic int cnt_w(input int out_w);
    return (out_w > 1) ? $clog2(out_w) : 1;
  endfunction

  localparam int IN_W_DEF    = 32;
  localparam int OUT_W_DEF   = IN_W_DEF / 2;
  localparam int CNT_W_DEF   = cnt_w(OUT_W_DEF);
  localparam int REM_W_DEF   = OUT_W_DEF + 1;
  localparam int TRIAL_W_DEF = OUT_W_DEF + 3;

endpackage

// File: rtl/isqrt_step.sv
// -----------------------------------------------------------------------------
// isqrt_step
// One restoring digit-by-digit square root iteration (purely combinational).
// Brings down two radicand bits, performs a single trial subtraction and
// produces the next partial remainder and partial root.
// Ports:
//   rem_i   [OUT_W:0]   partial remainder in
//   proot_i [OUT_W-1:0] partial root in
//   bits_i  [1:0]       next two radicand bits (MSB first)
//   rem_o   [OUT_W:0]   partial remainder out
//   proot_o [OUT_W-1:0] partial root out
// -----------------------------------------------------------------------------
module isqrt_step
  import isqrt_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [OUT_W:0]   rem_i,
  input  logic [OUT_W-1:0] proot_i,
  input  logic [1:0]       bits_i,
  output logic [OUT_W:0]   rem_o,
  output logic [OUT_W-1:0] proot_o
);

  localparam int TRIAL_W = OUT_W + 3;

  logic [TRIAL_W-1:0] r_shift;
  logic [TRIAL_W-1:0] trial;
  logic [OUT_W:0]     diff;

  always_comb begin
    // Full OUT_W+3 bit compare: the shifted remainder may exceed the
    // remainder register width before the subtraction brings it back.
    r_shift = {rem_i, bits_i};
    trial   = {1'b0, proot_i, 2'b01};
    // Only the low bits of the difference survive; modular subtraction
    // gives them exactly whenever r_shift >= trial.
    diff    = r_shift[OUT_W:0] - trial[OUT_W:0];
    if (r_shift >= trial) begin
      rem_o   = diff;
      proot_o = {proot_i[OUT_W-2:0], 1'b1};
    end else begin
      rem_o   = r_shift[OUT_W:0];
      proot_o = {proot_i[OUT_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/isqrt_seq.sv
// -----------------------------------------------------------------------------
// isqrt_seq
// Sequential integer square root: root = floor(sqrt(radicand)) and
// remainder = radicand - root^2, one root bit per clock (restoring method).
// Build option: define ISQRT_ROUND_EN to round the root to nearest
// (saturating); the remainder always refers to the floor root.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   radicand present            in_ready  block can accept
//   radicand   [IN_W-1:0] unsigned operand
//   out_valid  result present              out_ready consumer accepts
//   root       [OUT_W-1:0] square root
//   remainder  [OUT_W:0]   radicand - floor_root^2
//   busy       high while iterating
// Parameter: IN_W (even, >= 4). OUT_W = IN_W/2 is derived internally.
//
// state | meaning
// IDLE  | waiting for a radicand (in_ready=1 once out of reset)
// CALC  | one root bit per cycle, cnt counts OUT_W-1 down to 0
// DONE  | result held on root/remainder until out_ready
// -----------------------------------------------------------------------------
module isqrt_seq
  import isqrt_pkg::*;
#(
  parameter int IN_W = IN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   radicand,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IN_W/2-1:0] root,
  output logic [IN_W/2:0]   remainder,
  output logic              busy
);

  localparam int OUT_W = IN_W / 2;
  localparam int CNT_W = cnt_w(OUT_W);
  localparam int REM_W = OUT_W + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IN_W-1:0]    rad_q, rad_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [OUT_W-1:0]   proot_q, proot_d;
  logic               rdy_q;

  logic [REM_W-1:0]   step_rem;
  logic [OUT_W-1:0]   step_proot;
  logic [OUT_W-1:0]   root_fin;

  isqrt_step #(
    .OUT_W (OUT_W)
  ) u_step (
    .rem_i   (rem_q),
    .proot_i (proot_q),
    .bits_i  (rad_q[IN_W-1 -: 2]),
    .rem_o   (step_rem),
    .proot_o (step_proot)
  );

`ifdef ISQRT_ROUND_EN
  // Round to nearest: x - r^2 > r  <=>  x >= (r + 0.5)^2 for integer x.
  always_comb begin
    root_fin = step_proot;
    if ((step_rem > {1'b0, step_proot}) && (step_proot != {OUT_W{1'b1}})) begin
      root_fin = step_proot + {{(OUT_W-1){1'b0}}, 1'b1};
    end
  end
`else
  assign root_fin = step_proot;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    proot_d = proot_q;
    case (state_q)
      IDLE: begin
        if (in_valid && rdy_q) begin
          rad_d   = radicand;
          rem_d   = '0;
          proot_d = '0;
          cnt_d   = CNT_W'(OUT_W - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        rad_d = {rad_q[IN_W-3:0], 2'b00};
        rem_d = step_rem;
        if (cnt_q == '0) begin
          proot_d = root_fin;
          state_d = DONE;
        end else begin
          proot_d = step_proot;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rad_q   <= '0;
      rem_q   <= '0;
      proot_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      proot_q <= proot_d;
      rdy_q   <= 1'b1;
    end
  end

  // rdy_q keeps in_ready low until the first clock after reset release.
  assign in_ready  = (state_q == IDLE) && rdy_q;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC);
  assign root      = proot_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_isqrt_seq.sv
module tb_isqrt_seq;

  localparam int IN_W  = 32;
  localparam int OUT_W = IN_W / 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  radicand;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] root;
  logic [OUT_W:0]   remainder;
  logic             busy;

  isqrt_seq #(.IN_W(IN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .radicand  (radicand),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .root      (root),
    .remainder (remainder),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] r;
    logic [OUT_W:0]   m;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  exp_t        sb[$];
  int unsigned acc_q[$];
  bit          prev_ov  = 1'b0;
  bit          rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: largest r with r*r <= x by binary search, plus optional rounding.
  function automatic exp_t model(input logic [IN_W-1:0] x);
    exp_t e;
    longint unsigned lo, hi, mid, xv;
    xv = longint'(x);
    lo = 0;
    hi = (64'd1 << OUT_W) - 1;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= xv) lo = mid;
      else hi = mid - 1;
    end
    e.r = OUT_W'(lo);
    e.m = (OUT_W+1)'(xv - lo * lo);
`ifdef ISQRT_ROUND_EN
    if ((longint'(e.m) > lo) && (lo != (64'd1 << OUT_W) - 1)) e.r = OUT_W'(lo + 1);
`endif
    return e;
  endfunction

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: inputs only change just after a rising edge, so the falling edge
  // sees exactly what the next rising edge will act on.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        sb.push_back(model(radicand));
        acc_q.push_back(cyc);
      end
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) flag("latency_without_accept");
        else check("latency_cycles", longint'(cyc - acc_q.pop_front()), OUT_W + 1);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          flag("unexpected_result");
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("root", longint'(root), longint'(e.r));
          check("remainder", longint'(remainder), longint'(e.m));
        end
      end
      prev_ov = out_valid;
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = 1'($urandom % 2);
    end
  end

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [IN_W-1:0] x);
    int n;
    n = 0;
    radicand = x;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) flag("send_timeout");
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 3000) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 3000) flag("drain_timeout");
    check("scoreboard_empty", sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OUT_W-1:0] exp_r99;
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    radicand  = '0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_root", root, 0);
    check("rst_remainder", remainder, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("in_ready_before_first_clock", in_ready, 0);
    @(posedge clk);
    #1 check("in_ready_after_release", in_ready, 1);

    // Directed values; out_ready already high before DONE.
    out_ready = 1'b1;
    send(32'd0);
    send(32'd1000000);
    send(32'd1);
    send(32'd99);
    send(32'hFFFF_FFFF);
    send(32'd4);
    send(32'd3);
    drain();

    // Hold in DONE with out_ready low; a second in_valid must be ignored.
`ifdef ISQRT_ROUND_EN
    exp_r99 = 16'd10;
`else
    exp_r99 = 16'd9;
`endif
    out_ready = 1'b0;
    send(32'd99);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 100) flag("done_timeout");
    radicand = 32'd7;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_root", root, exp_r99);
      check("hold_remainder", remainder, 18);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    send(32'd144);
    drain();

    // Reset in the middle of CALC aborts the operation.
    send(32'd1000);
    repeat (4) @(posedge clk);
    #1 check("busy_mid_calc", busy, 1);
    #1 rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_root", root, 0);
    check("abort_remainder", remainder, 0);
    sb.delete();
    acc_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 send(32'd2);
    drain();

    // Randomised traffic with random backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [IN_W-1:0] x;
      logic [OUT_W-1:0] k;
      k = OUT_W'($urandom);
      case ($urandom % 4)
        0: x = $urandom;
        1: x = IN_W'(k) * IN_W'(k);
        2: x = IN_W'(k) * IN_W'(k) - 1;
        default: x = IN_W'($urandom % 1024);
      endcase
      send(x);
      repeat ($urandom % 3) @(posedge clk);
      #1;
    end
    drain();
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
